// File: rtl/fs_accel_bpbuf_ctrl.sv
// Sequencer/arbiter for the single-word bypass buffer: moves a programmed
// number of words from NREQ round-robin requesters through the buffer to one
// downstream consumer, reloading the buffer on drain for 1 word/cycle.
module fs_accel_bpbuf_ctrl #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int CNTW = 16,
    parameter int SRCW = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [CNTW-1:0]     xfer_len,
    output logic                busy,
    output logic                done,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [DW-1:0]       bpbuf_di,
    output logic                bpbuf_ld_wrn,
    output logic                bpbuf_enb,
    input  logic [DW-1:0]       bpbuf_do,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    input  logic                out_ready,
    output logic [SRCW-1:0]     out_src
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FULL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [CNTW-1:0]   len_q, len_d;
    logic [SRCW-1:0]   rr_q, rr_d;
    logic [SRCW-1:0]   src_q, src_d;

    logic [DW-1:0]     req_word [NREQ];
    logic              grant_found;
    logic [SRCW-1:0]   grant_idx;
    int                cand;
    logic              arb_en;
    logic              last_word;
    logic [CNTW:0]     count_inc;

    // Unpack the flat requester data bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_word[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // The transfer ends when the word being delivered is the len-th one.
    assign count_inc = {1'b0, count_q} + {{CNTW{1'b0}}, 1'b1};
    assign last_word = (count_inc == {1'b0, len_q});

    // Round-robin pick: first valid requester scanning from rr+1 modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(rr_q) + k) % NREQ;
            if (!grant_found && req_valid[cand[SRCW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SRCW-1:0];
            end
        end
    end

    // Arbitration runs while waiting for a word, or while draining a
    // non-final word so the buffer can be refilled in the same cycle.
    assign arb_en = (state_q == GRANT) ||
                    ((state_q == FULL) && out_ready && !last_word);

    // Next-state and output decode; buffer load only on a live handshake.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        len_d        = len_q;
        rr_d         = rr_q;
        src_d        = src_q;
        req_ready    = '0;
        bpbuf_di     = '0;
        bpbuf_ld_wrn = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        out_valid    = 1'b0;

        if (arb_en && grant_found) begin
            req_ready[grant_idx] = 1'b1;
            bpbuf_di             = req_word[grant_idx];
            bpbuf_ld_wrn         = 1'b1;
            rr_d                 = grant_idx;
            src_d                = grant_idx;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (xfer_len != '0) begin
                        len_d   = xfer_len;
                        count_d = '0;
                        state_d = GRANT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            GRANT: begin
                busy = 1'b1;
                if (grant_found) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_inc[CNTW-1:0];
                        state_d = grant_found ? FULL : GRANT;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bpbuf_enb = bpbuf_ld_wrn;
    assign out_data  = bpbuf_do;
    assign out_src   = src_q;

    // State registers; rr starts at NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
            rr_q    <= SRCW'(NREQ - 1);
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
        end
    end

endmodule
